// File: rtl/bcd2bin_pkg.sv
// Shared types and sizing for the signed three-digit BCD to binary converter.
// Sizes cover the full 000..999 magnitude range.
package bcd2bin_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam int DIGITS      = 3;
    localparam int MAG_WIDTH   = 10;
    localparam int SHIFT_COUNT = 10;
    localparam int CNT_W       = 4;
    localparam int SR_W        = DIGITS * 4 + MAG_WIDTH;
    localparam int EXT_W       = 17;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One reverse double-dabble correction cell: a nibble of 8 or more loses 3.
// Purely combinational.
module bcd_digit_adjust (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd8) begin
            dout = din - 4'd3;
        end
    end

endmodule

// File: rtl/bcd2bin.sv
// Signed BCD (sign + H/T/U) to WORD_LENGTH-bit two's complement, 11 enabled cycles per conversion.
// start is only honoured in IDLE; enable low freezes everything.
module bcd2bin
    import bcd2bin_pkg::*;
#(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   sign,
    input  logic [3:0]             H,
    input  logic [3:0]             T,
    input  logic [3:0]             U,
    output logic [WORD_LENGTH-1:0] bin,
    output logic                   ready,
    output logic                   error,
    output logic                   busy
);

    localparam logic [EXT_W-1:0] POS_LIM = EXT_W'((1 << (WORD_LENGTH - 1)) - 1);
    localparam logic [EXT_W-1:0] NEG_LIM = EXT_W'(1 << (WORD_LENGTH - 1));

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SR_W-1:0]        sr_q, sr_d;
    logic                   sign_q, sign_d;
    logic                   derr_q, derr_d;
    logic [WORD_LENGTH-1:0] bin_q, bin_d;
    logic                   ready_q, ready_d;
    logic                   error_q, error_d;

    logic [SR_W-1:0]        shifted;
    logic [DIGITS*4-1:0]    adj;
    logic [EXT_W-1:0]       mag_ext;
    logic [EXT_W-1:0]       signed_val;
    logic                   out_of_range;

    assign shifted = {1'b0, sr_q[SR_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .din  (shifted[MAG_WIDTH + 4*g +: 4]),
            .dout (adj[4*g +: 4])
        );
    end

    assign mag_ext      = {{(EXT_W - MAG_WIDTH){1'b0}}, sr_q[MAG_WIDTH-1:0]};
    assign signed_val   = sign_q ? (EXT_W'(0) - mag_ext) : mag_ext;
    assign out_of_range = sign_q ? (mag_ext > NEG_LIM) : (mag_ext > POS_LIM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        sign_d  = sign_q;
        derr_d  = derr_q;
        bin_d   = bin_q;
        ready_d = ready_q;
        error_d = error_q;
        if (enable) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_d    = {H, T, U, {MAG_WIDTH{1'b0}}};
                        sign_d  = sign;
                        derr_d  = (H > 4'd9) || (T > 4'd9) || (U > 4'd9);
                        cnt_d   = CNT_W'(SHIFT_COUNT);
                        ready_d = 1'b0;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    sr_d  = {adj, shifted[MAG_WIDTH-1:0]};
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESULT;
                    end
                end
                RESULT: begin
                    // The digit check uses the flag taken at capture, not the shifted nibbles.
                    if (derr_q || out_of_range) begin
                        error_d = 1'b1;
                        bin_d   = '0;
                    end else begin
                        error_d = 1'b0;
                        bin_d   = signed_val[WORD_LENGTH-1:0];
                    end
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            sign_q  <= 1'b0;
            derr_q  <= 1'b0;
            bin_q   <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            sign_q  <= sign_d;
            derr_q  <= derr_d;
            bin_q   <= bin_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign bin   = bin_q;
    assign ready = ready_q;
    assign error = error_q;
    assign busy  = (state_q != IDLE);

endmodule
